// File: rtl/crossbar_seq.sv
// crossbar_seq: command sequencer in front of the 8x8 ReRAM crossbar MAC array.
// Turns WRITE_ROW / MAC commands into timed, registered line pulses and returns
// the captured column result over a valid/ready response channel.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; valid holds its payload stable until that edge, and ready never
// depends combinationally on valid.
//
// Optional feature macro: CROSSBAR_FORM_TRACK_EN (per-row forming tracking;
// the first write to a row uses a FORM_CYC forming pulse with xb_form high).
module crossbar_seq #(
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned FORM_CYC  = 16,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned GAP_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [2:0] cmd_row,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic [7:0] xb_bitline,
    output logic [7:0] xb_wordline,
    output logic [7:0] xb_selectline,
    output logic       xb_wenable,
    output logic       xb_form,
    output logic       xb_mac,
    input  logic [7:0] xb_out,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] FORM_LD  = 8'(FORM_CYC - 1);
    localparam logic [7:0] READ_LD  = 8'(READ_LAT - 1);
    localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] bitline_q, bitline_d;
    logic [7:0] wordline_q, wordline_d;
    logic [7:0] selectline_q, selectline_d;
    logic       wen_q, wen_d;
    logic       mac_q, mac_d;
    logic       form_q, form_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       form_now;

`ifdef CROSSBAR_FORM_TRACK_EN
    logic [7:0] formed_q, formed_d;
`endif

    // A new command only enters when idle and no result is waiting to be read.
    assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;

    // Next-state, line and response logic; every target defaults to hold.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitline_d    = bitline_q;
        wordline_d   = wordline_q;
        selectline_d = selectline_q;
        wen_d        = wen_q;
        mac_d        = mac_q;
        form_d       = form_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        form_now     = 1'b0;
`ifdef CROSSBAR_FORM_TRACK_EN
        formed_d     = formed_q;
        form_now     = !formed_q[cmd_row];
`endif

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (!cmd_op) begin
                        // SET where data is 1, RESET where data is 0, in one pulse.
                        bitline_d    = cmd_data;
                        selectline_d = ~cmd_data;
                        wordline_d   = 8'd1 << cmd_row;
                        wen_d        = 1'b1;
                        form_d       = form_now;
                        cnt_d        = form_now ? FORM_LD : PULSE_LD;
                        state_d      = WRITE;
                    end else begin
                        bitline_d    = 8'h00;
                        selectline_d = 8'h00;
                        wordline_d   = cmd_data;
                        mac_d        = 1'b1;
                        cnt_d        = READ_LD;
                        state_d      = READ;
                    end
                end
            end
            WRITE: begin
                if (cnt_q == 8'd0) begin
`ifdef CROSSBAR_FORM_TRACK_EN
                    // The row counts as formed only once its pulse has finished.
                    if (form_q) begin
                        formed_d = formed_q | wordline_q;
                    end
`endif
                    bitline_d    = 8'h00;
                    wordline_d   = 8'h00;
                    selectline_d = 8'h00;
                    wen_d        = 1'b0;
                    form_d       = 1'b0;
                    cnt_d        = GAP_LD;
                    state_d      = GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            READ: begin
                if (cnt_q == 8'd0) begin
                    rsp_data_d   = xb_out;
                    rsp_valid_d  = 1'b1;
                    bitline_d    = 8'h00;
                    wordline_d   = 8'h00;
                    selectline_d = 8'h00;
                    mac_d        = 1'b0;
                    cnt_d        = GAP_LD;
                    state_d      = GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, line and response registers; reset clears every line at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            bitline_q    <= 8'h00;
            wordline_q   <= 8'h00;
            selectline_q <= 8'h00;
            wen_q        <= 1'b0;
            mac_q        <= 1'b0;
            form_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitline_q    <= bitline_d;
            wordline_q   <= wordline_d;
            selectline_q <= selectline_d;
            wen_q        <= wen_d;
            mac_q        <= mac_d;
            form_q       <= form_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

`ifdef CROSSBAR_FORM_TRACK_EN
    // Per-row formed flags; a reset during forming leaves the row unformed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            formed_q <= 8'h00;
        end else begin
            formed_q <= formed_d;
        end
    end
    assign xb_form = form_q;
`else
    assign xb_form = 1'b0;
`endif

    assign xb_bitline    = bitline_q;
    assign xb_wordline   = wordline_q;
    assign xb_selectline = selectline_q;
    assign xb_wenable    = wen_q;
    assign xb_mac        = mac_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign busy          = (state_q != IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_crossbar_seq.sv
// Testbench for crossbar_seq. Expected line waveforms are derived from the
// command timing rules: for a pulse of length D cycles, counting k = clocks
// since the accepting edge, lines are driven for k < D, everything is low but
// busy for D <= k < D+GAP, and the sequencer is idle again at k = D+GAP.
module tb_crossbar_seq;

    localparam int P = 4;
    localparam int F = 16;
    localparam int L = 2;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [2:0] cmd_row = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       busy;
    logic [7:0] xb_bitline, xb_wordline, xb_selectline;
    logic       xb_wenable, xb_form, xb_mac;
    logic [7:0] xb_out = 8'h00;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int last_wait = 0;
    logic [7:0] formed_m = 8'h00;

    crossbar_seq #(
        .PULSE_CYC(P), .FORM_CYC(F), .READ_LAT(L), .GAP_CYC(G)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy),
        .xb_bitline(xb_bitline), .xb_wordline(xb_wordline), .xb_selectline(xb_selectline),
        .xb_wenable(xb_wenable), .xb_form(xb_form), .xb_mac(xb_mac),
        .xb_out(xb_out), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check the always-true line rules.
    task automatic cycle();
        @(negedge clk);
        check("no_bl_sl_overlap", xb_bitline & xb_selectline, 0);
        check("no_wen_mac_overlap", xb_wenable & xb_mac, 0);
        if (!busy) begin
            check("idle_lines_zero",
                  {xb_bitline, xb_wordline, xb_selectline, xb_wenable, xb_form, xb_mac}, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bl"}, xb_bitline, 0);
        check({tag, "_wl"}, xb_wordline, 0);
        check({tag, "_sl"}, xb_selectline, 0);
        check({tag, "_strobes"}, {xb_wenable, xb_form, xb_mac}, 0);
    endtask

    // rdy_mode: 0 = rsp_ready held high, 1..4 = release after rdy_mode-1 extra
    // cycles, 5 = leave the result pending. keep leaves cmd_valid high afterwards.
    task automatic do_cmd(input bit op, input logic [2:0] row, input logic [7:0] data,
                          input logic [7:0] xb, input int rdy_mode, input bit keep);
        logic [7:0] e_bl, e_wl, e_sl;
        bit e_wen, e_form, e_mac, on, exp_v;
        int d;
        e_wen = 1'b0; e_form = 1'b0; e_mac = 1'b0;
        if (op) begin
            e_bl = 8'h00; e_sl = 8'h00; e_wl = data; e_mac = 1'b1; d = L;
        end else begin
            e_bl = data; e_sl = ~data; e_wl = 8'd1 << row; e_wen = 1'b1;
`ifdef CROSSBAR_FORM_TRACK_EN
            e_form = !formed_m[row];
`endif
            d = e_form ? F : P;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_data = data;
        xb_out = ~xb;
        rsp_ready = (rdy_mode == 0);
        last_wait = 0;
        while (!cmd_ready && last_wait < 60) begin
            cycle();
            last_wait++;
        end
        if (!cmd_ready) begin
            n_tests++; n_fail++;
            $error("FAIL accept_timeout: got cmd_ready 0 expected 1 within 60 cycles");
            cmd_valid = 1'b0;
            return;
        end
        cycle();
        if (!keep) cmd_valid = 1'b0;
        for (int k = 0; k <= d + G; k++) begin
            on = (k < d);
            check("bitline", xb_bitline, on ? e_bl : 8'h00);
            check("wordline", xb_wordline, on ? e_wl : 8'h00);
            check("selectline", xb_selectline, on ? e_sl : 8'h00);
            check("wenable", xb_wenable, on & e_wen);
            check("form", xb_form, on & e_form);
            check("mac", xb_mac, on & e_mac);
            check("busy", busy, k < d + G);
            check("cmd_ready", cmd_ready, (k == d + G) && !(op && rdy_mode != 0));
            if (op) begin
                exp_v = (k >= d) && (rdy_mode != 0 || k == d);
                check("rsp_valid", rsp_valid, exp_v);
                if (exp_v) check("rsp_data", rsp_data, xb);
                // Only the correct capture edge sees the real column value.
                if (k == d - 1) xb_out = xb;
                else if (k == d) xb_out = xb ^ 8'h5A;
            end else begin
                check("rsp_valid_write", rsp_valid, 0);
            end
            if (k < d + G) cycle();
        end
        if (!op) formed_m[row] = 1'b1;
        if (op && rdy_mode >= 1 && rdy_mode <= 4) begin
            cmd_valid = 1'b1; cmd_op = 1'($urandom); cmd_data = 8'($urandom);
            for (int w = 0; w < rdy_mode - 1; w++) begin
                cycle();
                check("pend_valid", rsp_valid, 1);
                check("pend_data", rsp_data, xb);
                check("pend_blocked", cmd_ready, 0);
                check("pend_busy", busy, 0);
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            cycle();
            check("rsp_cleared", rsp_valid, 0);
            check("ready_after_rsp", cmd_ready, 1);
        end
        if (rdy_mode != 5) rsp_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] d8;
        // Reset values
        #1 rst_n = 1'b0;
        cycle();
        cycle();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_busy", busy, 0);
        check_all_zero("rst");
        rst_n = 1'b1;
        cycle();

        // Directed WRITE_ROW row 2, data 0xA5
        do_cmd(1'b0, 3'd2, 8'hA5, 8'h00, 0, 1'b0);
        // MAC 0xFF, array returns 0x3C, result held until rsp_ready pulses
        do_cmd(1'b1, 3'd0, 8'hFF, 8'h3C, 4, 1'b0);
        // MAC with empty activation vector returns 0x00
        do_cmd(1'b1, 3'd0, 8'h00, 8'h00, 0, 1'b0);
        // Back-to-back: WRITE_ROW row 0 then MAC with cmd_valid held high
        do_cmd(1'b0, 3'd0, 8'h3F, 8'h00, 0, 1'b1);
        do_cmd(1'b1, 3'd0, 8'h81, 8'hC3, 0, 1'b0);
        check("b2b_wait", last_wait, 0);
        // Same row twice: forming pulse first time only (when tracking is built in)
        do_cmd(1'b0, 3'd5, 8'h5A, 8'h00, 0, 1'b0);
        do_cmd(1'b0, 3'd5, 8'hC3, 8'h00, 0, 1'b0);

        // Reset in the second cycle of a write pulse
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_row = 3'd3; cmd_data = 8'h96;
        check("pre_abort_ready", cmd_ready, 1);
        cycle();
        cmd_valid = 1'b0;
        cycle();
        check("abort_wen_on", xb_wenable, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        check("abort_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        formed_m = 8'h00;
        cycle();
        rst_n = 1'b1;
        cycle();
        check("post_abort_ready", cmd_ready, 1);
        check("post_abort_busy", busy, 0);

        // Reset drops a pending result
        do_cmd(1'b1, 3'd0, 8'h0F, 8'hE7, 5, 1'b0);
        check("pending_before_rst", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_drops_rsp", rsp_valid, 0);
        check("rst_clears_data", rsp_data, 8'h00);
        cycle();
        rst_n = 1'b1;
        rsp_ready = 1'b0;
        cycle();

        // Randomized command mix
        for (int i = 0; i < 40; i++) begin
            d8 = 8'($urandom);
            do_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), d8,
                   8'($urandom), $urandom_range(0, 4), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
